// File: rtl/frame_bram_arbiter_if.sv
// Client, capture and BRAM-side signals of frame_bram_arbiter, bundled for connection.
interface frame_bram_arbiter_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 8
);
  logic              start_capture;
  logic              frame_start;
  logic              cap_valid;
  logic [DATA_W-1:0] cap_data;
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_rvalid;
  logic              disp_miss;
  logic              proc_req;
  logic              proc_we;
  logic [ADDR_W-1:0] proc_addr;
  logic [DATA_W-1:0] proc_wdata;
  logic              proc_gnt;
  logic              proc_rvalid;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_din;
  logic              bram_we;
  logic [DATA_W-1:0] bram_dout;
  logic [1:0]        state;
  logic              frame_ready;
  logic              cap_short;

  modport slave (
    input  start_capture, frame_start, cap_valid, cap_data,
    input  disp_req, disp_addr, proc_req, proc_we, proc_addr, proc_wdata, bram_dout,
    output disp_rvalid, disp_miss, proc_gnt, proc_rvalid, rdata,
    output bram_addr, bram_din, bram_we, state, frame_ready, cap_short
  );

  modport master (
    output start_capture, frame_start, cap_valid, cap_data,
    output disp_req, disp_addr, proc_req, proc_we, proc_addr, proc_wdata, bram_dout,
    input  disp_rvalid, disp_miss, proc_gnt, proc_rvalid, rdata,
    input  bram_addr, bram_din, bram_we, state, frame_ready, cap_short
  );
endinterface

// File: rtl/frame_bram_arbiter.sv
// Capture FSM plus one-access-per-cycle frame BRAM arbiter; read data returns RD_LAT cycles after grant.
// No backpressure: losers see disp_miss / proc_gnt=0 and retry; `PROC_STARVE_GUARD_EN lets starved processing outrank display.
module frame_bram_arbiter #(
  parameter int ADDR_W       = 18,
  parameter int DATA_W       = 8,
  parameter int FRAME_PIXELS = 256000,
  parameter int RD_LAT       = 1,
  parameter int STARVE_MAX   = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  frame_bram_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, CAPTURE = 2'd2, READY = 2'd3} state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                ready_q, ready_d;
  logic                short_q, short_d;
  logic [RD_LAT-1:0]   disp_tag_q, proc_tag_q;

  logic                cap_wr, proc_ok, boost, disp_win, proc_win;
  logic [ADDR_W-1:0]   cap_addr;

`ifdef PROC_STARVE_GUARD_EN
  logic [4:0] starve_q, starve_d;
  assign boost = (starve_q >= 5'(STARVE_MAX));

  always_comb begin
    starve_d = '0;
    if (bus.proc_req && !proc_win)
      starve_d = (starve_q >= 5'(STARVE_MAX)) ? starve_q : starve_q + 5'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_q <= '0;
    else        starve_q <= starve_d;
  end
`else
  logic [4:0] unused_starve_max;
  assign unused_starve_max = 5'(STARVE_MAX);
  assign boost = 1'b0;
`endif

  // A pixel arriving together with frame_start is pixel 0 of the new frame.
  always_comb begin
    cap_wr   = bus.cap_valid && ((state_q == CAPTURE) || ((state_q == ARMED) && bus.frame_start));
    cap_addr = bus.frame_start ? '0 : cnt_q;
    proc_ok  = bus.proc_req && (!bus.proc_we || (state_q == READY));
    proc_win = !cap_wr && proc_ok && (boost || !bus.disp_req);
    disp_win = !cap_wr && bus.disp_req && !(boost && proc_ok);
  end

  always_comb begin
    bus.bram_we   = 1'b0;
    bus.bram_addr = '0;
    bus.bram_din  = '0;
    if (rst_n) begin
      if (cap_wr) begin
        bus.bram_we   = 1'b1;
        bus.bram_addr = cap_addr;
        bus.bram_din  = bus.cap_data;
      end else if (disp_win) begin
        bus.bram_addr = bus.disp_addr;
      end else if (proc_win) begin
        bus.bram_we   = bus.proc_we;
        bus.bram_addr = bus.proc_addr;
        bus.bram_din  = bus.proc_we ? bus.proc_wdata : '0;
      end
    end
    bus.proc_gnt  = rst_n && proc_win;
    bus.disp_miss = rst_n && bus.disp_req && !disp_win;
    bus.rdata     = rst_n ? bus.bram_dout : '0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    short_d = short_q;
    unique case (state_q)
      IDLE: if (bus.start_capture) state_d = ARMED;
      ARMED: begin
        if (bus.frame_start) begin
          state_d = CAPTURE;
          cnt_d   = cap_wr ? ADDR_W'(1) : '0;
        end
      end
      CAPTURE: begin
        if (bus.frame_start) begin
          short_d = 1'b1;
          cnt_d   = cap_wr ? ADDR_W'(1) : '0;
        end else if (cap_wr) begin
          if (cnt_q == LAST_ADDR) begin
            state_d = READY;
            ready_d = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
      end
      READY: begin
        if (bus.start_capture) begin
          state_d = ARMED;
          ready_d = 1'b0;
          short_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      short_q    <= 1'b0;
      disp_tag_q <= '0;
      proc_tag_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ready_q       <= ready_d;
      short_q       <= short_d;
      disp_tag_q[0] <= disp_win;
      proc_tag_q[0] <= proc_win && !bus.proc_we;
      for (int i = 1; i < RD_LAT; i++) begin
        disp_tag_q[i] <= disp_tag_q[i-1];
        proc_tag_q[i] <= proc_tag_q[i-1];
      end
    end
  end

  assign bus.state       = state_q;
  assign bus.frame_ready = ready_q;
  assign bus.cap_short   = short_q;
  assign bus.disp_rvalid = disp_tag_q[RD_LAT-1];
  assign bus.proc_rvalid = proc_tag_q[RD_LAT-1];

endmodule

// File: tb/tb_frame_bram_arbiter.sv
// Bench for frame_bram_arbiter: directed vectors, corner sequences and random traffic against a transaction model.
module tb_frame_bram_arbiter;
  localparam int ADDR_W = 18, DATA_W = 8, FP = 16, RD_LAT = 1, STARVE_MAX = 16;

  logic clk, rst_n;
  frame_bram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  frame_bram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FRAME_PIXELS(FP),
                       .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port BRAM behavioural model, read-first, RD_LAT cycles.
  logic [7:0] bram_mem [0:(1<<ADDR_W)-1];
  logic [7:0] dpipe [RD_LAT];
  always @(posedge clk) begin
    if (bus.bram_we) bram_mem[bus.bram_addr] <= bus.bram_din;
    dpipe[0] <= bram_mem[bus.bram_addr];
    for (int i = 1; i < RD_LAT; i++) dpipe[i] <= dpipe[i-1];
  end
  assign bus.bram_dout = dpipe[RD_LAT-1];

  int checks = 0, errors = 0, cyc = 0;

  // Reference model: frame state, expected memory contents and outstanding read returns.
  int         m_state, m_cnt, m_starve;
  bit         m_ready, m_short;
  logic [7:0] m_mem [256];
  bit         m_known [256];
  typedef struct { int due; bit is_disp; logic [7:0] d; bit known; } ret_t;
  ret_t rq[$];

  typedef struct {
    bit dreq; bit preq; bit pwe;
    logic [17:0] da; logic [17:0] pa; logic [7:0] wd;
    bit ewe; logic [17:0] ea; bit egnt; bit emiss;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input bit sc, input bit fs, input bit cv, input logic [7:0] cd,
                       input bit dr, input logic [17:0] da,
                       input bit pr, input bit pw, input logic [17:0] pa, input logic [7:0] wd);
    bus.start_capture = sc; bus.frame_start = fs; bus.cap_valid = cv; bus.cap_data = cd;
    bus.disp_req = dr; bus.disp_addr = da;
    bus.proc_req = pr; bus.proc_we = pw; bus.proc_addr = pa; bus.proc_wdata = wd;
  endtask

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_starve = 0; m_ready = 0; m_short = 0;
    rq.delete();
  endtask

  // Called at a falling edge with inputs applied; checks, advances the model, returns at the next falling edge.
  task automatic step();
    bit cap_wr, proc_ok, boost, ewe, edv, epv, rknown;
    int win, ai;
    logic [17:0] ea;
    logic [7:0] ed, rd;
    #1;
    cap_wr  = bus.cap_valid && (m_state == 2 || (m_state == 1 && bus.frame_start));
    proc_ok = bus.proc_req && (!bus.proc_we || m_state == 3);
`ifdef PROC_STARVE_GUARD_EN
    boost = (m_starve >= STARVE_MAX);
`else
    boost = 1'b0;
`endif
    // winner: 0 none, 1 capture, 2 display, 3 processing
    win = 0;
    if (cap_wr)                win = 1;
    else if (boost && proc_ok) win = 3;
    else if (bus.disp_req)     win = 2;
    else if (proc_ok)          win = 3;
    ewe = 0; ea = '0; ed = '0;
    case (win)
      1: begin ewe = 1; ea = bus.frame_start ? 18'd0 : 18'(m_cnt); ed = bus.cap_data; end
      2: ea = bus.disp_addr;
      3: begin ewe = bus.proc_we; ea = bus.proc_addr; ed = bus.proc_wdata; end
      default: ;
    endcase
    chk("bram_we", bus.bram_we, ewe);
    chk("bram_addr", bus.bram_addr, ea);
    if (ewe) chk("bram_din", bus.bram_din, ed);
    chk("proc_gnt", bus.proc_gnt, win == 3);
    chk("disp_miss", bus.disp_miss, bus.disp_req && win != 2);
    chk("state", bus.state, m_state);
    chk("frame_ready", bus.frame_ready, m_ready);
    chk("cap_short", bus.cap_short, m_short);
    edv = 0; epv = 0; rknown = 0; rd = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      edv = rq[0].is_disp; epv = !rq[0].is_disp; rknown = rq[0].known; rd = rq[0].d;
      void'(rq.pop_front());
    end
    chk("disp_rvalid", bus.disp_rvalid, edv);
    chk("proc_rvalid", bus.proc_rvalid, epv);
    if ((edv || epv) && rknown) chk("rdata", bus.rdata, rd);

    ai = int'(ea[7:0]);
    if (win == 2 || (win == 3 && !bus.proc_we))
      rq.push_back('{cyc + RD_LAT, win == 2, m_mem[ai], m_known[ai]});
    if (ewe) begin m_mem[ai] = ed; m_known[ai] = 1; end
    if (bus.proc_req && win != 3) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : m_starve;
    else m_starve = 0;
    case (m_state)
      0: if (bus.start_capture) m_state = 1;
      1: if (bus.frame_start) begin m_state = 2; m_cnt = cap_wr ? 1 : 0; end
      2: if (bus.frame_start) begin
           m_short = 1; m_cnt = cap_wr ? 1 : 0;
         end else if (cap_wr) begin
           if (m_cnt == FP - 1) begin m_state = 3; m_ready = 1; m_cnt = 0; end
           else m_cnt++;
         end
      3: if (bus.start_capture) begin m_state = 1; m_ready = 0; m_short = 0; end
      default: ;
    endcase
    @(posedge clk); cyc++;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(0, 0, 0, 8'h00, 0, 18'd0, 0, 0, 18'd0, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin m_mem[i] = '0; m_known[i] = 0; end
    model_reset();
    tbl[0] = '{0, 0, 0, 18'd0,  18'd0,  8'h00, 0, 18'd0,  0, 0};
    tbl[1] = '{1, 0, 0, 18'd9,  18'd0,  8'h00, 0, 18'd9,  0, 0};
    tbl[2] = '{0, 1, 0, 18'd0,  18'd12, 8'h00, 0, 18'd12, 1, 0};
    tbl[3] = '{0, 1, 1, 18'd0,  18'd3,  8'hAA, 1, 18'd3,  1, 0};
    tbl[4] = '{1, 1, 1, 18'd4,  18'd7,  8'h11, 0, 18'd4,  0, 0};
    tbl[5] = '{1, 1, 0, 18'd2,  18'd8,  8'h00, 0, 18'd2,  0, 0};
    tbl[6] = '{0, 1, 1, 18'd0,  18'd20, 8'h5A, 1, 18'd20, 1, 0};

    // Reset holds every output low even with requests present.
    rst_n = 1'b0;
    drive(1, 1, 1, 8'h33, 1, 18'd5, 1, 0, 18'd6, 8'h00);
    #2;
    chk("rst_bram_addr", bus.bram_addr, 0);
    chk("rst_bram_we", bus.bram_we, 0);
    chk("rst_disp_miss", bus.disp_miss, 0);
    chk("rst_proc_gnt", bus.proc_gnt, 0);
    chk("rst_state", bus.state, 0);
    chk("rst_frame_ready", bus.frame_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();

    // Full frame of 16 pixels.
    drive(1, 0, 0, 8'h00, 0, 18'd0, 0, 0, 18'd0, 8'h00); step();
    drive(0, 1, 0, 8'h00, 0, 18'd0, 0, 0, 18'd0, 8'h00); step();
    for (int i = 0; i < FP; i++) begin
      drive(0, 0, 1, 8'(i), 0, 18'd0, 0, 0, 18'd0, 8'h00);
      #1 chk("cap_addr", bus.bram_addr, i);
      step();
    end
    idle();
    #1 chk("frame_state_ready", bus.state, 3);
    chk("frame_ready_set", bus.frame_ready, 1);
    step();

    // Display and processing collide on address 5.
    drive(0, 0, 0, 8'h00, 1, 18'd5, 1, 0, 18'd5, 8'h00);
    #1 chk("collide_proc_wait", bus.proc_gnt, 0);
    step();
    drive(0, 0, 0, 8'h00, 0, 18'd0, 1, 0, 18'd5, 8'h00);
    #1 chk("disp_rvalid_a5", bus.disp_rvalid, 1);
    chk("disp_rdata_a5", bus.rdata, 8'h05);
    chk("proc_gnt_second", bus.proc_gnt, 1);
    step();
    idle();
    #1 chk("proc_rvalid_a5", bus.proc_rvalid, 1);
    chk("proc_rdata_a5", bus.rdata, 8'h05);
    step();

    // Arbitration table in READY.
    for (int i = 0; i < 7; i++) begin
      drive(0, 0, 0, 8'h00, tbl[i].dreq, tbl[i].da, tbl[i].preq, tbl[i].pwe, tbl[i].pa, tbl[i].wd);
      #1 chk("tbl_we", bus.bram_we, tbl[i].ewe);
      chk("tbl_addr", bus.bram_addr, tbl[i].ea);
      chk("tbl_gnt", bus.proc_gnt, tbl[i].egnt);
      chk("tbl_miss", bus.disp_miss, tbl[i].emiss);
      step();
    end
    drive(0, 0, 0, 8'h00, 0, 18'd0, 1, 0, 18'd3, 8'h00); step();
    idle();
    #1 chk("readback_a3_vld", bus.proc_rvalid, 1);
    chk("readback_a3", bus.rdata, 8'hAA);
    step();

    // ARMED: writes refused, reads allowed.
    drive(1, 0, 0, 8'h00, 0, 18'd0, 0, 0, 18'd0, 8'h00); step();
    drive(0, 0, 0, 8'h00, 0, 18'd0, 1, 1, 18'd3, 8'h55);
    #1 chk("armed_write_denied", bus.proc_gnt, 0);
    step();
    drive(0, 0, 0, 8'h00, 0, 18'd0, 1, 0, 18'd3, 8'h00);
    #1 chk("armed_read_gnt", bus.proc_gnt, 1);
    step();
    drive(0, 1, 0, 8'h00, 0, 18'd0, 0, 0, 18'd0, 8'h00); step();

    // Capture beats display; short frame then a full one.
    drive(0, 0, 1, 8'h40, 1, 18'd9, 0, 0, 18'd0, 8'h00);
    #1 chk("conflict_miss", bus.disp_miss, 1);
    chk("conflict_we", bus.bram_we, 1);
    step();
    drive(0, 0, 1, 8'h41, 0, 18'd0, 0, 0, 18'd0, 8'h00);
    #1 chk("conflict_no_rvalid", bus.disp_rvalid, 0);
    step();
    for (int i = 2; i < 7; i++) begin drive(0, 0, 1, 8'(8'h40 + i), 0, 18'd0, 0, 0, 18'd0, 8'h00); step(); end
    drive(0, 1, 0, 8'h00, 0, 18'd0, 0, 0, 18'd0, 8'h00); step();
    idle();
    #1 chk("cap_short_set", bus.cap_short, 1);
    for (int i = 0; i < FP; i++) begin
      drive(0, 0, 1, 8'(8'h80 + i), 0, 18'd0, 0, 0, 18'd0, 8'h00);
      if (i == 0) #1 chk("restart_addr0", bus.bram_addr, 0);
      step();
    end
    idle();
    #1 chk("short_frame_ready", bus.state, 3);
    chk("cap_short_sticky", bus.cap_short, 1);
    step();
    drive(1, 0, 0, 8'h00, 0, 18'd0, 0, 0, 18'd0, 8'h00); step();
    idle();
    #1 chk("cap_short_cleared", bus.cap_short, 0);
    step();

    // Display hogging the BRAM against a waiting processing read.
    for (int k = 0; k <= 16; k++) begin
      drive(0, 0, 0, 8'h00, 1, 18'(k), 1, 0, 18'd20, 8'h00);
      #1;
      if (k < 16) chk("starve_wait", bus.proc_gnt, 0);
      else begin
`ifdef PROC_STARVE_GUARD_EN
        chk("starve_gnt17", bus.proc_gnt, 1);
        chk("starve_miss17", bus.disp_miss, 1);
`else
        chk("starve_fixed_gnt", bus.proc_gnt, 0);
        chk("starve_fixed_miss", bus.disp_miss, 0);
`endif
      end
      step();
    end
    idle(); step();

    // Asynchronous reset in the middle of a capture.
    drive(0, 1, 0, 8'h00, 0, 18'd0, 0, 0, 18'd0, 8'h00); step();
    for (int i = 0; i < 3; i++) begin drive(0, 0, 1, 8'(8'hC0 + i), 0, 18'd0, 0, 0, 18'd0, 8'h00); step(); end
    drive(0, 0, 1, 8'h77, 1, 18'd2, 1, 0, 18'd4, 8'h00);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_bram_we", bus.bram_we, 0);
    chk("arst_bram_addr", bus.bram_addr, 0);
    chk("arst_bram_din", bus.bram_din, 0);
    chk("arst_proc_gnt", bus.proc_gnt, 0);
    chk("arst_disp_miss", bus.disp_miss, 0);
    chk("arst_state", bus.state, 0);
    chk("arst_frame_ready", bus.frame_ready, 0);
    chk("arst_cap_short", bus.cap_short, 0);
    chk("arst_disp_rvalid", bus.disp_rvalid, 0);
    chk("arst_proc_rvalid", bus.proc_rvalid, 0);
    chk("arst_rdata", bus.rdata, 0);
    model_reset();
    @(posedge clk); cyc++;
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post_rst_idle", bus.state, 0);
    step();
    step();

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 15) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
            8'($urandom), $urandom_range(0, 2) == 0, 18'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0, 18'($urandom_range(0, 31)),
            8'($urandom));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
